// File: rtl/vram_pkg.sv
// Shared constants for the VRAM port arbiter.
//   VRAM geometry (address/data width, implemented depth), stall counter width,
//   read FSM state encodings and the per-cycle port grant type.
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 11;
  localparam int VRAM_DEPTH  = 4800;
  localparam int VRAM_CNT_W  = 16;

  // CPU read FSM encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_FWD     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Owner of the single VRAM port in the current cycle
  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_VGA    = 2'd1,
    GNT_CPU_RD = 2'd2,
    GNT_DRAIN  = 2'd3
  } grant_t;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted write buffer for CPU writes to VRAM.
//   clk, rst           clock, async active-high reset (entry discarded)
//   load, load_addr,
//   load_data          capture a new entry at the edge (wins over drain)
//   drain              entry is written to VRAM this cycle; clears valid
//   valid, addr, data  current entry
//   match_addr, match  valid entry holding match_addr (read forwarding)
module vram_wbuf
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match
);

  // Load and drain in the same cycle: the old entry leaves through the port
  // while the new one takes its place, so valid stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  assign match = valid && (addr == match_addr);

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single-port synchronous-read VRAM between VGA scan-out and the CPU.
// VGA reads always win; CPU writes are posted through a one-entry buffer with
// read forwarding; CPU reads stall until they get a port slot.
//   clk, rst                       clock, async active-high reset
//   vga_req/vga_addr               VGA read request (never stalled)
//   vga_valid/vga_data             VGA read data, one cycle after vga_req
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata                      CPU access, held until cpu_ready
//   cpu_ready/cpu_rdata/cpu_wait   CPU completion, read data, stall
//   vram_addr/vram_we/vram_din     VRAM port, combinational from the grant
//   vram_dout                      VRAM read data, 1-cycle latency
//   stall_cnt                      saturating count of cpu_wait cycles
//
// Read FSM
//   state      | meaning
//   IDLE       | no read in progress; accept new read
//   RD_REQ     | read waiting for a cycle without vga_req
//   RD_DATA    | VRAM data returning; ack read
//   FWD        | ack read from the write buffer (or 0 when out of range)
//   DONE       | dead cycle so the held request is not re-accepted
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = VRAM_DEPTH,
  parameter int CNT_W  = VRAM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [DATA_W-1:0] fwd_data_q;
  logic              vga_valid_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  grant_t            grant;
  logic              cpu_in_range;
  logic              drain;
  logic              wr_window;
  logic              wr_ack;
  logic              rd_ack;
  logic              wbuf_load;
  logic              wbuf_valid;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0] wbuf_data;
  logic              wbuf_match;

  assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH_L);

  // One op per cycle: VGA, then a pending CPU read, then the buffered write.
  always_comb begin
    grant = GNT_NONE;
    if (vga_req)
      grant = GNT_VGA;
    else if (state_q == ST_RD_REQ)
      grant = GNT_CPU_RD;
    else if (wbuf_valid)
      grant = GNT_DRAIN;
  end

  assign drain = (grant == GNT_DRAIN);

  always_comb begin
    vram_addr = '0;
    vram_we   = 1'b0;
    vram_din  = '0;
    case (grant)
      GNT_VGA:    vram_addr = vga_addr;
      GNT_CPU_RD: vram_addr = cpu_addr;
      GNT_DRAIN: begin
        vram_addr = wbuf_addr;
        vram_we   = 1'b1;
        vram_din  = wbuf_data;
      end
      default: ;
    endcase
  end

  // Writes are only taken while no read owns the CPU handshake. The ack is
  // combinational: the slot is free if empty or emptied by this cycle's drain.
  assign wr_window = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign wr_ack    = cpu_req && cpu_we && wr_window && (!wbuf_valid || drain);
  // Out-of-range writes are acknowledged but never reach the buffer.
  assign wbuf_load = wr_ack && cpu_in_range;

  vram_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (wbuf_load),
    .load_addr  (cpu_addr),
    .load_data  (cpu_wdata),
    .drain      (drain),
    .valid      (wbuf_valid),
    .addr       (wbuf_addr),
    .data       (wbuf_data),
    .match_addr (cpu_addr),
    .match      (wbuf_match)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !cpu_we) begin
          if (!cpu_in_range || wbuf_match)
            state_d = ST_FWD;
          else
            state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (grant == GNT_CPU_RD)
          state_d = ST_RD_DATA;
      end
      ST_RD_DATA: state_d = ST_DONE;
      ST_FWD:     state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fwd_data_q  <= '0;
      vga_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      vga_valid_q <= vga_req;
      // Snapshot the forwarded value when the read is accepted, so a drain
      // in the same cycle cannot change what the CPU sees.
      if ((state_q == ST_IDLE) && (state_d == ST_FWD))
        fwd_data_q <= wbuf_match ? wbuf_data : '0;
      if (cpu_wait && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign rd_ack    = (state_q == ST_RD_DATA) || (state_q == ST_FWD);
  assign cpu_ready = wr_ack || rd_ack;
  assign cpu_wait  = cpu_req && !cpu_ready;

  always_comb begin
    cpu_rdata = '0;
    if (state_q == ST_RD_DATA)
      cpu_rdata = vram_dout;
    else if (state_q == ST_FWD)
      cpu_rdata = fwd_data_q;
  end

  assign vga_valid = vga_valid_q;
  assign vga_data  = vga_valid_q ? vram_dout : '0;
  assign stall_cnt = stall_cnt_q;

endmodule
